// File: rtl/led_cnt_sched.sv
// Round-robin write arbiter plus autonomous divider sweep for the led_cnt div/wren port.
// Optional build macro LED_CNT_SCHED_PINGPONG_EN: sweep bounces between bounds instead of wrapping.
module led_cnt_sched #(
  parameter int                 NREQ    = 2,
  parameter int                 DIV_W   = 5,
  parameter int                 DWELL_W = 27,
  parameter logic [DIV_W-1:0]   DIV_RST = DIV_W'(1)
) (
  input  logic                    clk100,
  input  logic                    rstn,
  input  logic [NREQ-1:0]         req_i,
  input  logic [NREQ*DIV_W-1:0]   div_req_i,
  output logic [NREQ-1:0]         gnt_o,
  input  logic                    sweep_en_i,
  input  logic [DIV_W-1:0]        sweep_lo_i,
  input  logic [DIV_W-1:0]        sweep_hi_i,
  input  logic [DWELL_W-1:0]      dwell_i,
  output logic [DIV_W-1:0]        div_o,
  output logic                    wren_o,
  output logic                    busy_o
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  // state | meaning:  IDLE | only grants write;  SWEEP | stepping div_o every dwell cycles
  typedef enum logic {IDLE, SWEEP} state_t;

  state_t             state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [DWELL_W-1:0] dwell_cnt;
  logic               sweep_en_q;

  logic [NREQ-1:0]    req_rot;
  logic               found;
  logic [PTR_W-1:0]   win;
  logic [PTR_W-1:0]   ptr_nxt;
  logic [DIV_W-1:0]   div_sel;
  logic [DIV_W-1:0]   next_div;
  logic [DWELL_W-1:0] dwell_ld;
  logic               sweep_rise;

  // Rotate so bit 0 is the requester the pointer currently favours.
  assign req_rot = NREQ'({req_i, req_i} >> rr_ptr);

  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_rot[i]) begin
        found = 1'b1;
        win   = PTR_W'((int'(rr_ptr) + i) % NREQ);
      end
    end
    div_sel = div_req_i[int'(win)*DIV_W +: DIV_W];
  end

  assign ptr_nxt    = (win == PTR_W'(NREQ - 1)) ? '0 : win + 1'b1;
  assign dwell_ld   = (dwell_i == '0) ? DWELL_W'(1) : dwell_i;
  assign sweep_rise = sweep_en_i && !sweep_en_q;

`ifdef LED_CNT_SCHED_PINGPONG_EN
  logic dir_up;
  logic next_dir_up;

  always_comb begin
    next_dir_up = dir_up;
    if (sweep_lo_i >= sweep_hi_i) begin
      next_div = sweep_lo_i;
    end else if (dir_up) begin
      if (div_o >= sweep_hi_i) begin
        next_div    = div_o - 1'b1;
        next_dir_up = 1'b0;
      end else begin
        next_div = div_o + 1'b1;
      end
    end else begin
      if (div_o <= sweep_lo_i) begin
        next_div    = div_o + 1'b1;
        next_dir_up = 1'b1;
      end else begin
        next_div = div_o - 1'b1;
      end
    end
  end
`else
  // An inverted range lands here on every step, so it keeps rewriting sweep_lo_i.
  assign next_div = (div_o >= sweep_hi_i) ? sweep_lo_i : div_o + 1'b1;
`endif

  always_ff @(posedge clk100 or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      dwell_cnt  <= '0;
      sweep_en_q <= 1'b0;
      div_o      <= DIV_RST;
      wren_o     <= 1'b0;
      gnt_o      <= '0;
      busy_o     <= 1'b0;
`ifdef LED_CNT_SCHED_PINGPONG_EN
      dir_up     <= 1'b1;
`endif
    end else begin
      sweep_en_q <= sweep_en_i;
      gnt_o      <= '0;
      wren_o     <= 1'b0;
      if (found) begin
        // A grant always wins and ends any sweep; the enable edge is consumed regardless.
        gnt_o  <= NREQ'(1) << win;
        div_o  <= div_sel;
        wren_o <= 1'b1;
        rr_ptr <= ptr_nxt;
        state  <= IDLE;
        busy_o <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (sweep_rise) begin
              state     <= SWEEP;
              busy_o    <= 1'b1;
              div_o     <= sweep_lo_i;
              wren_o    <= 1'b1;
              dwell_cnt <= dwell_ld;
`ifdef LED_CNT_SCHED_PINGPONG_EN
              dir_up    <= 1'b1;
`endif
            end
          end
          SWEEP: begin
            if (!sweep_en_i) begin
              state  <= IDLE;
              busy_o <= 1'b0;
            end else if (dwell_cnt <= DWELL_W'(1)) begin
              div_o     <= next_div;
              wren_o    <= 1'b1;
              dwell_cnt <= dwell_ld;
`ifdef LED_CNT_SCHED_PINGPONG_EN
              dir_up    <= next_dir_up;
`endif
            end else begin
              dwell_cnt <= dwell_cnt - 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_cnt_sched.sv
// Bench for led_cnt_sched: time-scheduled reference model checked every cycle plus directed literal checks.
module tb_led_cnt_sched;
  localparam int NREQ    = 2;
  localparam int DIV_W   = 5;
  localparam int DWELL_W = 27;

  logic                  clk100 = 1'b0;
  logic                  rstn;
  logic [NREQ-1:0]       req;
  logic [NREQ*DIV_W-1:0] div_req;
  logic [NREQ-1:0]       gnt_o;
  logic                  sweep_en;
  logic [DIV_W-1:0]      sweep_lo;
  logic [DIV_W-1:0]      sweep_hi;
  logic [DWELL_W-1:0]    dwell;
  logic [DIV_W-1:0]      div_o;
  logic                  wren_o;
  logic                  busy_o;

  led_cnt_sched #(.NREQ(NREQ), .DIV_W(DIV_W), .DWELL_W(DWELL_W)) dut (
    .clk100(clk100), .rstn(rstn), .req_i(req), .div_req_i(div_req), .gnt_o(gnt_o),
    .sweep_en_i(sweep_en), .sweep_lo_i(sweep_lo), .sweep_hi_i(sweep_hi), .dwell_i(dwell),
    .div_o(div_o), .wren_o(wren_o), .busy_o(busy_o)
  );

  always #5 clk100 = ~clk100;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: sweep writes scheduled at absolute cycle numbers.
  int              m_cyc, m_div, m_ptr, m_next;
  logic            m_busy, m_wren, m_prev_en, m_up;
  logic [NREQ-1:0] m_gnt;

  always @(posedge clk100 or negedge rstn) begin
    int k, idx, dw, lo, hi;
    bit rise;
    logic [NREQ-1:0]       rtmp;
    logic [NREQ*DIV_W-1:0] dtmp;
    logic [NREQ-1:0]       one;
    if (!rstn) begin
      m_cyc = 0; m_div = 1; m_ptr = 0; m_next = 0;
      m_busy = 0; m_wren = 0; m_prev_en = 0; m_up = 1; m_gnt = '0;
    end else begin
      m_cyc++;
      rise = sweep_en && !m_prev_en;
      m_prev_en = sweep_en;
      dw = (dwell == 0) ? 1 : int'(dwell);
      lo = int'(sweep_lo);
      hi = int'(sweep_hi);
      k = -1;
      for (int i = 0; i < NREQ; i++) begin
        idx  = (m_ptr + i) % NREQ;
        rtmp = req >> idx;
        if (k < 0 && rtmp[0]) k = idx;
      end
      m_gnt  = '0;
      m_wren = 0;
      if (k >= 0) begin
        one    = 1;
        m_gnt  = one << k;
        dtmp   = div_req >> (k * DIV_W);
        m_div  = int'(dtmp[DIV_W-1:0]);
        m_wren = 1;
        m_ptr  = (k + 1) % NREQ;
        m_busy = 0;
      end else if (!m_busy) begin
        if (rise) begin
          m_busy = 1; m_div = lo; m_wren = 1; m_next = m_cyc + dw; m_up = 1;
        end
      end else if (!sweep_en) begin
        m_busy = 0;
      end else if (m_cyc == m_next) begin
`ifdef LED_CNT_SCHED_PINGPONG_EN
        if (lo >= hi) m_div = lo;
        else if (m_up && m_div >= hi) begin m_up = 0; m_div = m_div - 1; end
        else if (!m_up && m_div <= lo) begin m_up = 1; m_div = m_div + 1; end
        else m_div = m_up ? m_div + 1 : m_div - 1;
`else
        m_div = (lo > hi || m_div >= hi) ? lo : m_div + 1;
`endif
        m_wren = 1;
        m_next = m_cyc + dw;
      end
    end
  end

  int n_cyc = 0;
  int log_v[$];
  int log_t[$];

  always @(negedge clk100) begin
    chk("div_o", int'(div_o), m_div);
    chk("wren_o", int'(wren_o), int'(m_wren));
    chk("gnt_o", int'(gnt_o), int'(m_gnt));
    chk("busy_o", int'(busy_o), int'(m_busy));
    n_cyc++;
    if (wren_o) begin
      log_v.push_back(int'(div_o));
      log_t.push_back(n_cyc);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk100);
      #1;
    end
  endtask

  task automatic clear_log();
    log_v.delete();
    log_t.delete();
  endtask

  task automatic check_log(input string nm, input int ev[$], input int sp);
    chk({nm, "_count"}, log_v.size(), ev.size());
    for (int i = 0; i < ev.size() && i < log_v.size(); i++) begin
      chk({nm, "_val"}, log_v[i], ev[i]);
      if (i > 0) chk({nm, "_spacing"}, log_t[i] - log_t[i-1], sp);
    end
  endtask

  initial begin
    int e[$];
    rstn = 0; req = '0; div_req = '0; sweep_en = 0;
    sweep_lo = '0; sweep_hi = '0; dwell = '0;
    tick(2);
    rstn = 1;
    chk("rst_div", int'(div_o), 1);
    chk("rst_wren", int'(wren_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_gnt", int'(gnt_o), 0);
    tick(2);

    // Round robin with both requesters held
    req = 2'b11; div_req = {5'h07, 5'h03};
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("rr_div", int'(div_o), (i % 2) ? 7 : 3);
      chk("rr_gnt", int'(gnt_o), (i % 2) ? 2 : 1);
      chk("rr_wren", int'(wren_o), 1);
    end
    req = '0;
    tick(2);

    // Sweep lo=2 hi=4 dwell=3
    sweep_lo = 5'd2; sweep_hi = 5'd4; dwell = 27'd3; sweep_en = 1;
    clear_log();
    tick(13);
`ifdef LED_CNT_SCHED_PINGPONG_EN
    e = '{2, 3, 4, 3, 2};
`else
    e = '{2, 3, 4, 2, 3};
`endif
    check_log("sweep", e, 3);
    chk("sweep_busy", int'(busy_o), 1);

    // Override by requester 1 while sweeping
    req = 2'b10; div_req = {5'h1F, 5'h03};
    tick(1);
    chk("ovr_div", int'(div_o), 31);
    chk("ovr_gnt", int'(gnt_o), 2);
    chk("ovr_busy", int'(busy_o), 0);
    req = '0;
    clear_log();
    tick(10);
    chk("ovr_quiet", log_v.size(), 0);

    // dwell=0 acts as 1
    sweep_en = 0; tick(2);
    dwell = '0; sweep_lo = 5'd2; sweep_hi = 5'd4; sweep_en = 1;
    clear_log();
    tick(3);
    e = '{2, 3, 4};
    check_log("dwell0", e, 1);

    // Inverted range keeps writing lo
    sweep_en = 0; tick(2);
    sweep_lo = 5'd6; sweep_hi = 5'd4; dwell = 27'd2; sweep_en = 1;
    clear_log();
    tick(7);
    e = '{6, 6, 6, 6};
    check_log("degen", e, 2);

    // Request and sweep edge in the same cycle
    sweep_en = 0; tick(2);
    sweep_lo = 5'd2; sweep_hi = 5'd4; dwell = 27'd2;
    req = 2'b01; div_req = {5'h1F, 5'h09}; sweep_en = 1;
    clear_log();
    tick(1);
    chk("simul_div", int'(div_o), 9);
    chk("simul_gnt", int'(gnt_o), 1);
    chk("simul_busy", int'(busy_o), 0);
    req = '0;
    tick(6);
    chk("simul_writes", log_v.size(), 1);

    // Reset in the middle of a sweep
    sweep_en = 0; tick(2);
    sweep_lo = 5'd2; sweep_hi = 5'd4; dwell = 27'd3; sweep_en = 1;
    tick(4);
    #2;
    rstn = 0; sweep_en = 0;
    #1;
    chk("rst_mid_div", int'(div_o), 1);
    chk("rst_mid_wren", int'(wren_o), 0);
    chk("rst_mid_busy", int'(busy_o), 0);
    tick(1);
    rstn = 1;
    clear_log();
    tick(10);
    chk("rst_mid_quiet", log_v.size(), 0);

`ifdef LED_CNT_SCHED_PINGPONG_EN
    sweep_lo = 5'd1; sweep_hi = 5'd3; dwell = 27'd2; sweep_en = 1;
    clear_log();
    tick(11);
    e = '{1, 2, 3, 2, 1, 2};
    check_log("pingpong", e, 2);
    sweep_en = 0;
`endif

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
